// File: rtl/timer_if.sv
// -----------------------------------------------------------------------------
// timer_if
// Bus bundle between the system bridge and the countdown timer.
//   addr    bridge byte address (bits [1:0] ignored by the timer)
//   we      write strobe
//   byteen  per-byte write enables, bit i covers wdata[8i+7:8i]
//   wdata   write data
//   rdata   combinational read data from the timer
//   irq     interrupt request towards the CPU
// Modports: master = bridge / CPU side, slave = timer side.
// -----------------------------------------------------------------------------
interface timer_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, byteen, wdata, input rdata, irq);
    modport slave  (input addr, we, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
// Memory-mapped countdown timer with one-shot / auto-reload modes and a
// maskable interrupt. Four words decoded at BASE_ADDR:
//   +0x0 CTRL   [0]=EN [2:1]=MODE (01 auto-reload, else one-shot) [3]=IM
//   +0x4 PRESET reload value
//   +0x8 COUNT  read-only current count
//   +0xC PRESC  16-bit prescaler when TIMER_PRESCALE_EN is defined, else reads 0
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    timer_if.slave (addr, we, byteen, wdata in; rdata, irq out)
// Build option: define TIMER_PRESCALE_EN to add the PRESC register and the
// tick divider; otherwise the FSM advances every clock.
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic    clk,
    input  logic    reset,
    timer_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic [31:0] w_mask;
    logic [3:0]  w_ctrl_wval;
    logic        w_tick;
    logic        w_reload;
    logic [31:0] w_count_nxt;
    logic        w_flag_set;
    logic        w_flag_drop;
    logic        w_flag_wclr;
    logic        w_en_clr;
    logic [31:0] w_rdata;
    logic        w_unused;

    function automatic logic [31:0] f_byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Address decode: the four words share addr[31:4]; addr[1:0] is ignored.
    assign w_hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign w_off       = bus.addr[3:2];
    assign w_mask      = f_byte_mask(bus.byteen);
    assign w_wr_ctrl   = bus.we && w_hit && (w_off == 2'd0);
    assign w_wr_preset = bus.we && w_hit && (w_off == 2'd1);
    assign w_ctrl_wval = (r_ctrl & ~w_mask[3:0]) | (bus.wdata[3:0] & w_mask[3:0]);
    assign w_reload    = (r_ctrl[2:1] == 2'b01);
    assign w_unused    = ^bus.addr[1:0];

    // A pending flag is dropped when software rewrites PRESET or re-arms the
    // timer (CTRL write with EN=1). A CTRL write that only toggles IM keeps
    // the flag, so unmasking a completed one-shot raises irq.
    assign w_flag_wclr = w_wr_preset || (w_wr_ctrl && w_ctrl_wval[0]);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] r_presc;
    logic [15:0] r_div;
    logic        w_wr_presc;

    assign w_wr_presc = bus.we && w_hit && (w_off == 2'd3);
    assign w_tick     = (r_div == r_presc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_wr_presc) begin
            r_presc <= (r_presc & ~w_mask[15:0]) | (bus.wdata[15:0] & w_mask[15:0]);
        end
    end

    // Free-running divider; restarts on every CTRL write so a newly enabled
    // timer always sees a full prescale period before its first tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_wr_ctrl || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                2'd0: w_rdata = {28'd0, r_ctrl};
                2'd1: w_rdata = r_preset;
                2'd2: w_rdata = r_count;
`ifdef TIMER_PRESCALE_EN
                2'd3: w_rdata = {16'd0, r_presc};
`else
                2'd3: w_rdata = '0;
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata = w_rdata;
    assign bus.irq   = r_ctrl[3] & r_irq_flag;

    // FSM next-state and datapath decisions; nothing moves without a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_flag_set  = 1'b0;
        w_flag_drop = 1'b0;
        w_en_clr    = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (r_ctrl[0]) w_state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    w_count_nxt = r_preset;
                    w_state_nxt = S_CNT;
                end
                S_CNT: begin
                    if (!r_ctrl[0]) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_count > 32'd1) begin
                        w_count_nxt = r_count - 32'd1;
                    end else begin
                        // 0 and 1 both expire here, so COUNT never wraps.
                        w_count_nxt = '0;
                        w_flag_set  = 1'b1;
                        w_state_nxt = S_INT;
                    end
                end
                S_INT: begin
                    if (w_reload) begin
                        w_flag_drop = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_en_clr    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // A bus write to CTRL overrides the one-shot EN self-clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= w_ctrl_wval;
        end else if (w_en_clr) begin
            r_ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_preset <= '0;
        end else if (w_wr_preset) begin
            r_preset <= f_merge(r_preset, bus.wdata, w_mask);
        end
    end

    // Expiry beats a simultaneous software clear so no interrupt is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_flag_set) begin
            r_irq_flag <= 1'b1;
        end else if (w_flag_drop || w_flag_wclr) begin
            r_irq_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_PRESET = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_PRESC  = BASE + 32'hC;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] rv;

    timer_if bus_if ();

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_if.addr   = a;
        bus_if.wdata  = d;
        bus_if.byteen = be;
        bus_if.we     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.we     = 1'b0;
        bus_if.byteen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.addr = a;
        #1;
        d = bus_if.rdata;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        bus_if.addr   = '0;
        bus_if.we     = 1'b0;
        bus_if.byteen = 4'h0;
        bus_if.wdata  = '0;
        #12;
        rd(A_CTRL, rv);   check_val("rst_ctrl", rv, 32'h0);
        rd(A_COUNT, rv);  check_val("rst_count", rv, 32'h0);
        check_val("rst_irq", {31'd0, bus_if.irq}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);

        // Byte-masked PRESET write, COUNT is read-only, out-of-range reads 0
        wr(A_PRESET, 32'hAABB_CCDD, 4'b0010);
        rd(A_PRESET, rv); check_val("t5_preset", rv, 32'h0000_CC00);
        wr(A_COUNT, 32'h1234_5678, 4'hF);
        rd(A_COUNT, rv);  check_val("t5_count_ro", rv, 32'h0);
        rd(BASE + 32'h10, rv); check_val("oor_read", rv, 32'h0);

        // One-shot, PRESET=3, IM=1: irq after edge 5, held
        wr(A_PRESET, 32'd3, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick(2); rd(A_COUNT, rv); check_val("t2_cnt3", rv, 32'd3);
        tick(1); rd(A_COUNT, rv); check_val("t2_cnt2", rv, 32'd2);
        tick(1); rd(A_COUNT, rv); check_val("t2_cnt1", rv, 32'd1);
        check_val("t2_irq_early", {31'd0, bus_if.irq}, 32'h0);
        tick(1); rd(A_COUNT, rv); check_val("t2_cnt0", rv, 32'd0);
        check_val("t2_irq_rise", {31'd0, bus_if.irq}, 32'h1);
        tick(1); rd(A_CTRL, rv); check_val("t2_en_clr", rv, 32'h8);
        tick(3); check_val("t2_irq_held", {31'd0, bus_if.irq}, 32'h1);
        rd(A_COUNT, rv); check_val("t2_no_wrap", rv, 32'd0);
        wr(A_CTRL, 32'h0, 4'hF);
        check_val("t2_irq_drop", {31'd0, bus_if.irq}, 32'h0);

        // IM=0: flag sets silently, unmasking raises irq
        wr(A_PRESET, 32'd1, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        tick(4);
        check_val("t4_irq_masked", {31'd0, bus_if.irq}, 32'h0);
        rd(A_CTRL, rv); check_val("t4_en_clr", rv, 32'h0);
        wr(A_CTRL, 32'h8, 4'hF);
        check_val("t4_irq_unmask", {31'd0, bus_if.irq}, 32'h1);
        wr(A_CTRL, 32'h0, 4'hF);

        // Auto-reload PRESET=2: one-cycle pulse every 4 cycles
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        tick(2); rd(A_COUNT, rv); check_val("t3_load", rv, 32'd2);
        tick(2); check_val("t3_pulse1", {31'd0, bus_if.irq}, 32'h1);
        tick(1); check_val("t3_pulse1_end", {31'd0, bus_if.irq}, 32'h0);
        tick(1); rd(A_COUNT, rv); check_val("t3_reload", rv, 32'd2);
        tick(1); check_val("t3_gap", {31'd0, bus_if.irq}, 32'h0);
        tick(1); check_val("t3_pulse2", {31'd0, bus_if.irq}, 32'h1);
        rd(A_CTRL, rv); check_val("t3_en_kept", rv, 32'hB);
        wr(A_CTRL, 32'h0, 4'hF);
        tick(3);

        // Clearing EN mid-count freezes COUNT
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        tick(3); rd(A_COUNT, rv); check_val("frz_cnt4", rv, 32'd4);
        wr(A_CTRL, 32'h0, 4'hF);
        tick(3); rd(A_COUNT, rv); check_val("frz_held", rv, 32'd3);

        // Async reset mid-count
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick(2); rd(A_COUNT, rv); check_val("t1_pre", rv, 32'd5);
        #1;
        reset = 1'b0;
        rd(A_COUNT, rv);  check_val("t1_count", rv, 32'd0);
        rd(A_CTRL, rv);   check_val("t1_ctrl", rv, 32'd0);
        rd(A_PRESET, rv); check_val("t1_preset", rv, 32'd0);
        check_val("t1_irq", {31'd0, bus_if.irq}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);

        // PRESET=0 behaves like 1
        wr(A_CTRL, 32'h9, 4'hF);
        tick(2); check_val("p0_irq_low", {31'd0, bus_if.irq}, 32'h0);
        tick(1); check_val("p0_irq_rise", {31'd0, bus_if.irq}, 32'h1);
        rd(A_COUNT, rv); check_val("p0_count", rv, 32'd0);
        wr(A_PRESET, 32'd0, 4'hF);
        check_val("preset_wr_clr", {31'd0, bus_if.irq}, 32'h0);
        wr(A_CTRL, 32'h0, 4'hF);
        tick(2);

`ifdef TIMER_PRESCALE_EN
        // PRESC=1 doubles the latency: irq after edge 8 instead of 4
        wr(A_PRESC, 32'd1, 4'hF);
        rd(A_PRESC, rv); check_val("t6_presc", rv, 32'd1);
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick(7); check_val("t6_irq_low", {31'd0, bus_if.irq}, 32'h0);
        tick(1); check_val("t6_irq_rise", {31'd0, bus_if.irq}, 32'h1);
`else
        wr(A_PRESC, 32'hFFFF_FFFF, 4'hF);
        rd(A_PRESC, rv); check_val("presc_absent", rv, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
